pwm_decode: RTL and testbench

PWM_DECODE -- requirements
Module: pwm_decode

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_hi_cnt.sv | 20 ++
 rtl/pwm_decode.sv | 136 +++++++++++++
 tb/tb_pwm_decode.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty/direction decoder.
package pwm_pkg;

    localparam int PERIOD_DEF = 2048;
    localparam int SPD_W      = 11;
    localparam int CNT_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } pwm_state_e;

    // A full-period high count does not fit in SPD_W bits; clamp it to all-ones.
    function automatic logic [SPD_W-1:0] sat_spd(input logic [CNT_W-1:0] cnt);
        return (|cnt[CNT_W-1:SPD_W]) ? {SPD_W{1'b1}} : cnt[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_hi_cnt.sv
// High-cycle counter for one synchronized PWM line; cleared at each window end.
module pwm_hi_cnt
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_decode.sv
// Recovers speed and direction from a forward/reverse PWM pair, one result per window.
//   state      | meaning
//   ST_IDLE    | first window after reset, partial, result discarded
//   ST_MEASURE | counting a full window
//   ST_REPORT  | one cycle, new spd/rev/dir_err presented with vld
module pwm_decode
    import pwm_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PWM_frwrd,
    input  logic             PWM_rev,
    input  logic             clr_flt,
    output logic [SPD_W-1:0] spd,
    output logic             rev,
    output logic             vld,
    output logic             dir_err,
    output logic             shoot_thru
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(PERIOD - 1);

    logic [1:0]       frwrd_sync;
    logic [1:0]       rev_sync;
    logic             frwrd_s;
    logic             rev_s;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] frwrd_cnt;
    logic [CNT_W-1:0] rev_cnt;
    logic [CNT_W-1:0] frwrd_tot;
    logic [CNT_W-1:0] rev_tot;
    logic             win_end;
    logic             load;
    pwm_state_e       state;
    pwm_state_e       state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frwrd_sync <= '0;
            rev_sync   <= '0;
        end else begin
            frwrd_sync <= {frwrd_sync[0], PWM_frwrd};
            rev_sync   <= {rev_sync[0], PWM_rev};
        end
    end

    assign frwrd_s = frwrd_sync[1];
    assign rev_s   = rev_sync[1];

    always_ff @(posedge clk) begin
        if (rst || win_end) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + CNT_W'(1);
        end
    end

    assign win_end = (win_cnt == WIN_LAST);

    pwm_hi_cnt u_frwrd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (win_end),
        .en  (frwrd_s),
        .cnt (frwrd_cnt)
    );

    pwm_hi_cnt u_rev_cnt (
        .clk (clk),
        .rst (rst),
        .clr (win_end),
        .en  (rev_s),
        .cnt (rev_cnt)
    );

    // The window-end sample is folded in here while the counters restart from zero.
    assign frwrd_tot = frwrd_cnt + CNT_W'(frwrd_s);
    assign rev_tot   = rev_cnt + CNT_W'(rev_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (win_end) state_nxt = ST_MEASURE;
            ST_MEASURE: if (win_end) state_nxt = ST_REPORT;
            ST_REPORT:  state_nxt = ST_MEASURE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        vld  = (state == ST_REPORT);
        load = (state == ST_MEASURE) && win_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spd     <= '0;
            rev     <= 1'b0;
            dir_err <= 1'b0;
        end else if (load) begin
            spd     <= '0;
            dir_err <= 1'b0;
            if ((frwrd_tot != '0) && (rev_tot != '0)) begin
                dir_err <= 1'b1;
            end else if (frwrd_tot != '0) begin
                spd <= sat_spd(frwrd_tot);
                rev <= 1'b0;
            end else if (rev_tot != '0) begin
                spd <= sat_spd(rev_tot);
                rev <= 1'b1;
            end
        end
    end

    // Set wins over clear so an overlap in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            shoot_thru <= 1'b0;
        end else if (frwrd_s && rev_s) begin
            shoot_thru <= 1'b1;
        end else if (clr_flt) begin
            shoot_thru <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_decode.sv
// Scoreboard bench for pwm_decode: window patterns with hand-computed results.
module tb_pwm_decode;

    localparam int P = 2048;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        PWM_frwrd  = 1'b0;
    logic        PWM_rev    = 1'b0;
    logic        clr_flt    = 1'b0;
    logic [10:0] spd;
    logic        rev;
    logic        vld;
    logic        dir_err;
    logic        shoot_thru;

    always #5 clk = ~clk;

    pwm_decode #(.PERIOD(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .PWM_frwrd  (PWM_frwrd),
        .PWM_rev    (PWM_rev),
        .clr_flt    (clr_flt),
        .spd        (spd),
        .rev        (rev),
        .vld        (vld),
        .dir_err    (dir_err),
        .shoot_thru (shoot_thru)
    );

    typedef struct { int fd; int fp; int rd; int rp; int spd; int rev; int err; int mode; } win_t;
    typedef struct { int spd; int rev; int err; int due; } exp_t;
    typedef struct { int kind; int val; } probe_t;

    win_t   tbl[$];
    exp_t   exp_q[$];
    probe_t probe_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit done = 1'b0;

    // Cycle index since the last reset edge; the DUT window counter equals cyc % P.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    int h_spd = 0;
    int h_rev = 0;
    int h_err = 0;
    bit rst_pend = 1'b0;
    int hold_msgs = 0;

    always @(negedge clk) begin
        exp_t        e;
        probe_t      pr;
        logic [31:0] act;
        if (rst_pend) begin
            h_spd = 0; h_rev = 0; h_err = 0;
        end
        rst_pend = rst;
        while (probe_q.size() > 0) begin
            pr = probe_q.pop_front();
            case (pr.kind)
                0:       begin act = {31'b0, shoot_thru}; chk("shoot_thru", act, pr.val); end
                1:       begin act = {21'b0, spd};        chk("rst_spd", act, pr.val); end
                2:       begin act = {31'b0, rev};        chk("rst_rev", act, pr.val); end
                3:       begin act = {31'b0, dir_err};    chk("rst_dir_err", act, pr.val); end
                default: begin act = {31'b0, vld};        chk("rst_vld", act, pr.val); end
            endcase
        end
        if (vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vld: vld=1 at cycle %0d, want no vld", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("vld_cycle", cyc, e.due);
                chk("spd", {21'b0, spd}, e.spd);
                chk("rev", {31'b0, rev}, e.rev);
                chk("dir_err", {31'b0, dir_err}, e.err);
                h_spd = e.spd; h_rev = e.rev; h_err = e.err;
            end
        end else begin
            n_tests++;
            if (vld !== 1'b0 || {21'b0, spd} !== h_spd || {31'b0, rev} !== h_rev ||
                {31'b0, dir_err} !== h_err) begin
                n_fail++;
                if (hold_msgs < 20)
                    $display("FAIL hold: got vld=%b spd=%0d rev=%b dir_err=%b, want vld=0 spd=%0d rev=%0d dir_err=%0d (cycle %0d)",
                             vld, spd, rev, dir_err, h_spd, h_rev, h_err, cyc);
                hold_msgs++;
            end
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_vld: no vld seen, want vld at cycle %0d spd=%0d", e.due, e.spd);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    function automatic logic pat(input int p, input int d, input int ph);
        return ((p - ph + P) % P) < d;
    endfunction

    task automatic add(input int fd, input int fp, input int rd, input int rp,
                       input int s, input int rv, input int er, input int md);
        win_t w;
        w = '{fd, fp, rd, rp, s, rv, er, md};
        tbl.push_back(w);
    endtask

    task automatic probe(input int kind, input int val);
        probe_t pr;
        pr = '{kind, val};
        probe_q.push_back(pr);
    endtask

    // Drives every cycle of window idx (input time t = cyc + 2 absorbs the synchronizer).
    task automatic play(input win_t w, input int idx, output bit aborted);
        int     p;
        logic   f;
        logic   r;
        logic   c;
        exp_t   e;
        aborted = 1'b0;
        while ((cyc + 2) / P == idx) begin
            p = (cyc + 2) % P;
            f = pat(p, w.fd, w.fp);
            r = pat(p, w.rd, w.rp);
            c = 1'b0;
            if (w.mode == 1) begin
                if (p == 600) begin f = 1'b1; r = 1'b1; end
                if (p == 300 || p == 602) c = 1'b1;
                if (p == 100 || p == 301) probe(0, 0);
                if (p == 112 || p == 300 || p == 603 || p == 604) probe(0, 1);
            end
            if (w.mode == 2 && p == P - 1) probe(0, 0);
            PWM_frwrd = f;
            PWM_rev   = r;
            clr_flt   = c;
            if (w.mode == 3 && p == 1002) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                for (int k = 0; k < 5; k++) probe(k, 0);
                aborted = 1'b1;
                return;
            end
            if (p == P - 1 && idx >= 1) begin
                e = '{w.spd, w.rev, w.err, (idx + 1) * P};
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit ab;
        bit ab2;
        int widx;
        //   fd    fp    rd    rp    spd   rev err mode
        add(1024,    0,    0,    0, 1024,  0,  0,  0);
        add(1024,  700,    0,    0, 1024,  0,  0,  0);
        add(   0,    0,    5, 1234,    5,  1,  0,  0);
        add(   0,    0,    5, 2046,    5,  1,  0,  0);
        add(   0,    0,    0,    0,    0,  1,  0,  0);
        add(2048,    0,    0,    0, 2047,  0,  0,  0);
        add(   0,    0,    0,    0,    0,  0,  0,  0);
        add( 100,    0,  100,  500,    0,  0,  1,  2);
        add(   0,    0,    7,   10,    7,  1,  0,  0);
        add( 100,    0,  100, 1000,    0,  1,  1,  2);
        add(   1,    5,    0,    0,    1,  0,  0,  0);
        add(2047,    3,    0,    0, 2047,  0,  0,  0);
        add(  10,  100,   10,  109,    0,  0,  1,  1);
        add(   0,    0,    5,   50,    5,  1,  0,  0);
        add(1024,    0,    0,    0,    0,  0,  0,  3);
        add(1024,    0,    0,    0, 1024,  0,  0,  0);
        add(   0,    0, 2048,    0, 2047,  1,  0,  0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        play(tbl[0], 0, ab);
        widx = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            widx++;
            play(tbl[i], widx, ab);
            if (ab && i + 1 < tbl.size()) begin
                widx = 0;
                play(tbl[i + 1], 0, ab2);
            end
        end
        for (int k = 0; k < 16 && exp_q.size() > 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1 done = 1'b1;
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish within time limit, want finish");
        $fatal(1, "watchdog");
    end

endmodule
